// File: rtl/mem_burst_ctrl.sv
// Burst read/write sequencer for a 16 x 32-bit level-sensitive memory array.
// Every array control line is registered, so it only changes on a rising clk edge.
module mem_burst_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  cmd_done,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    // state | meaning
    // IDLE  | waiting for a command; cmd_ready high
    // WRITE | one array write per edge that sees wr_valid
    // READ  | one array read per cycle, data captured on the following edge
    // DONE  | single cycle with cmd_done; last beat's strobe still visible
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  cmd_done_q, cmd_done_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        cmd_done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                rd_valid_d  = 1'b0;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        // First read address goes out with the accept edge.
                        state_d       = S_READ;
                        mem_read_d    = 1'b1;
                        mem_address_d = cmd_addr;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    mem_address_d = addr_q;
                    mem_data_in_d = wr_data;
                    mem_write_d   = 1'b1;
                    addr_d        = addr_q + 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_d    = S_DONE;
                        cmd_done_d = 1'b1;
                    end
                end else begin
                    mem_write_d = 1'b0;
                end
            end
            S_READ: begin
                rd_data_d     = mem_data_out;
                rd_valid_d    = 1'b1;
                addr_d        = addr_q + 1'b1;
                mem_address_d = addr_q + 1'b1;
                cnt_d         = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    mem_read_d = 1'b0;
                    state_d    = S_DONE;
                    cmd_done_d = 1'b1;
                end
            end
            S_DONE: begin
                mem_write_d = 1'b0;
                rd_valid_d  = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            cmd_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            cmd_done_q    <= cmd_done_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign wr_ready    = (state_q == S_WRITE);
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign cmd_done    = cmd_done_q;

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Synchronous burst controller that sits directly upstream of the 4-bank, 16-entry × 32-bit memory array (`generate`d byte lanes). It accepts burst read/write commands from a host over a valid/ready handshake. It sequences the array's level-sensitive `read`, `write`, `address` and `data_in` lines one beat per cycle and returns read data with a one-cycle valid strobe. It replaces testbench-driven `#1` stimulus with clock-aligned, glitch-free memory control.

## Interface
- `DATA_WIDTH`, 32: beat width; equals the total width of the memory array (4 lanes × 8).
- `ADDR_WIDTH`, 4: memory address width, giving a depth of 16.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_WIDTH  burst start address.
- `cmd_len`  in  4  beats minus one (0 → 1 beat, 15 → 16 beats).
- `wr_data`  in  DATA_WIDTH  write beat data.
- `wr_valid`  in  1  write beat valid.
- `wr_ready`  out  1  controller accepts a write beat; high only in WRITE.
- `rd_data`  out  DATA_WIDTH  captured read data.
- `rd_valid`  out  1  `rd_data` valid this cycle; no backpressure.
- `cmd_done`  out  1  one-cycle pulse marking the final cycle of a burst.
- `mem_read`  out  1  to array `read`.
- `mem_write`  out  1  to array `write`.
- `mem_address`  out  ADDR_WIDTH  to array `address`.
- `mem_data_in`  out  DATA_WIDTH  to array `data_in`.
- `mem_data_out`  in  DATA_WIDTH  from array `data_out`; combinational from `read`/`address`.

## Operation
- States: IDLE, WRITE, READ, DONE. The state, beat counter, and all `mem_*`, `rd_*` and `cmd_done` outputs are registered.
- IDLE:
  - `cmd_ready` = 1.
  - On an edge with `cmd_valid`, latch the start address and the count `cmd_len`.
  - If `cmd_write` = 1, go to WRITE.
  - If `cmd_write` = 0, go to READ, with `mem_read` <= 1 and `mem_address` <= `cmd_addr` on the same edge.
- WRITE:
  - `wr_ready` = 1.
  - On an edge with `wr_valid`, register `mem_address` <= current address, `mem_data_in` <= `wr_data`, and `mem_write` <= 1. Then advance the address and decrement the count.
  - On an edge without `wr_valid`, `mem_write` <= 0 (stall). Address and data hold.
  - When the last beat is accepted (count was 0), go to DONE.
- READ:
  - Each edge: `rd_data` <= `mem_data_out`, `rd_valid` <= 1, `mem_address` <= address+1, count decrements.
  - On the edge where the count was 0, `mem_read` <= 0 and the state goes to DONE.
- DONE:
  - Lasts one cycle. `cmd_done` = 1.
  - The final write beat's `mem_write` is high, or the final read beat's `rd_valid` is high.
  - On the exit edge, clear `mem_write` and `rd_valid`, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: 15 wraps to 0 within a burst.
- `mem_address` and `mem_data_in` change only on clock edges. `mem_read` and `mem_write` are never high together.
- `cmd_valid` is ignored outside IDLE. `wr_valid` is ignored outside WRITE.

## Timing
- Reset values: state IDLE; `mem_read`, `mem_write`, `rd_valid` and `cmd_done` = 0; `mem_address`, `mem_data_in` and `rd_data` = 0. `cmd_ready` is 1 in the cycle after reset deasserts.
- Reset mid-burst: the next edge forces IDLE and the reset values. Remaining beats are dropped, no `cmd_done` is issued, and memory contents are untouched.
- Read burst of N beats, accepted at edge 0:
  - `mem_read` = 1 in cycles 1..N, with addresses a..a+N-1.
  - `rd_valid` = 1 in cycles 2..N+1.
  - `cmd_done` is in cycle N+1; `cmd_ready` is back in cycle N+2.
- Write burst of N beats, accepted at edge 0, with `wr_valid` held high:
  - Beats are accepted at edges 1..N.
  - `mem_write` = 1 in cycles 2..N+1.
  - `cmd_done` is in cycle N+1.
  - Each stall cycle on `wr_valid` adds one cycle.
- Throughput is 1 beat/cycle. Command turnaround costs 2 cycles (the DONE cycle plus the IDLE cycle).

## Test plan
- Reset then idle → all outputs 0; `cmd_ready` = 1; `mem_read`/`mem_write` stay 0 over 20 cycles with `cmd_valid` = 0.
- Write burst `cmd_addr`=0, `cmd_len`=15, `wr_data`=0x00010000+i held valid → `mem_write` high for 16 consecutive cycles, addresses 0..15; `cmd_done` in cycle 17.
- Read back `cmd_addr`=0, `cmd_len`=15 → `rd_valid` in cycles 2..17 with `rd_data` 0x00010000..0x0001000F in order; `cmd_done` coincides with the last beat.
- Wrap: write `cmd_addr`=14, `cmd_len`=3, data 0xA..0xD, then read the same span → addresses 14, 15, 0, 1; `rd_data` = 0xA, 0xB, 0xC, 0xD.
- Write stall: `cmd_len`=3 with `wr_valid` low on alternate cycles → `mem_write` low in each stall cycle; 4 writes total; `cmd_done` after the 4th beat; no duplicate writes.
- Reset during the 3rd beat of an 8-beat read → the next cycle shows `mem_read`=0, `rd_valid`=0, no `cmd_done`, `cmd_ready`=1; a following 1-beat read returns correct data.
